// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared widths and defaults for the MEM/WB pipeline slice. Also holds the
// bundle of control/data fields that cross the MEM->WB pipeline register.
// Optional feature macro used elsewhere in this slice: MEM_ALIGN_CHECK_EN.
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int WORD_W        = 32;   // data path / word width
    localparam int REG_W         = 5;    // register-file index width
    localparam int DEPTH_DEFAULT = 256;  // data-memory size in words

    // Fields carried unchanged (apart from gating) from MEM into WB.
    typedef struct packed {
        logic              memtoreg;
        logic              regwrite;
        logic [WORD_W-1:0] alu_result;
        logic [REG_W-1:0]  write_reg;
    } wb_ctrl_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_if
// Bundles the MEM-side inputs and WB-side outputs of mem_wb_stage.
//   master : the pipeline around the stage (drives MEM_*, observes WB_*)
//   slave  : mem_wb_stage itself
// MEM side : MEM_MemtoReg, MEM_RegWrite, MEM_MemRead, MEM_MemWrite,
//            alu_result_to_mem, write_data_to_mem, write_reg_to_mem
// WB side  : WB_MemtoReg, WB_RegWrite, read_data_to_wb, alu_result_to_wb,
//            write_reg_to_wb, wb_data, and misalign when MEM_ALIGN_CHECK_EN
//            is defined.
// ---------------------------------------------------------------------------
interface mem_wb_stage_if;
    import mem_pkg::*;

    logic              MEM_MemtoReg;
    logic              MEM_RegWrite;
    logic              MEM_MemRead;
    logic              MEM_MemWrite;
    logic [WORD_W-1:0] alu_result_to_mem;
    logic [WORD_W-1:0] write_data_to_mem;
    logic [REG_W-1:0]  write_reg_to_mem;

    logic              WB_MemtoReg;
    logic              WB_RegWrite;
    logic [WORD_W-1:0] read_data_to_wb;
    logic [WORD_W-1:0] alu_result_to_wb;
    logic [REG_W-1:0]  write_reg_to_wb;
    logic [WORD_W-1:0] wb_data;
`ifdef MEM_ALIGN_CHECK_EN
    logic              misalign;
`endif

    modport master (
`ifdef MEM_ALIGN_CHECK_EN
        input  misalign,
`endif
        output MEM_MemtoReg, MEM_RegWrite, MEM_MemRead, MEM_MemWrite,
        output alu_result_to_mem, write_data_to_mem, write_reg_to_mem,
        input  WB_MemtoReg, WB_RegWrite, read_data_to_wb,
        input  alu_result_to_wb, write_reg_to_wb, wb_data
    );

    modport slave (
`ifdef MEM_ALIGN_CHECK_EN
        output misalign,
`endif
        input  MEM_MemtoReg, MEM_RegWrite, MEM_MemRead, MEM_MemWrite,
        input  alu_result_to_mem, write_data_to_mem, write_reg_to_mem,
        output WB_MemtoReg, WB_RegWrite, read_data_to_wb,
        output alu_result_to_wb, write_reg_to_wb, wb_data
    );

endinterface

// File: rtl/mem_wb_stage_data_mem.sv
// ---------------------------------------------------------------------------
// data_mem
// Single-port synchronous word RAM with a registered read port that returns
// the pre-write (old) contents when read and write hit the same cycle.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-low reset (clears only the read register)
//   addr_i   in   word index
//   we_i     in   write enable (caller already gates it with reset)
//   re_i     in   read enable; when low the read register loads 0
//   wdata_i  in   write data
//   rdata_o  out  registered read data
// ---------------------------------------------------------------------------
module data_mem
    import mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     addr_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    // Declaration initialiser gives all-zero contents at start of simulation
    // (and a power-up init value on FPGA targets); reset never touches it.
    logic [WORD_W-1:0] mem_q [DEPTH] = '{default: '0};
    logic [WORD_W-1:0] rdata_q;

    // NOTE: the array has no reset branch on purpose; adding one would turn
    // the RAM into thousands of flops and defeat block-RAM inference.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // NOTE: non-blocking assignment is what makes this read see the value
    // before the write above lands, giving read-old-data behaviour.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= re_i ? mem_q[addr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
// MEM stage data-memory access plus the MEM/WB pipeline register.
// Loads have one-cycle latency: read_data_to_wb is valid alongside the WB
// controls of the same instruction. No stall/enable: every non-reset edge
// advances the pipeline.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous, active-low reset (suppresses memory writes)
//   bus  slave modport of mem_wb_stage_if (MEM inputs, WB outputs)
// Parameter:
//   DEPTH  data-memory size in 32-bit words (power of two, 16..4096)
// Build option:
//   MEM_ALIGN_CHECK_EN  adds bus.misalign; accesses with addr[1:0]!=0 are
//                       squashed (no write, zero read data, no reg write).
// ---------------------------------------------------------------------------
module mem_wb_stage
    import mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    mem_wb_stage_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] word_addr;
    logic          bad_access;
    logic          mem_we;
    logic          mem_re;
    wb_ctrl_t      wb_d;
    wb_ctrl_t      wb_q;

    // Address wraps modulo DEPTH*4: bits above the index are dropped.
    assign word_addr = bus.alu_result_to_mem[AW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_q;

    assign bad_access = (bus.MEM_MemRead | bus.MEM_MemWrite)
                      & (bus.alu_result_to_mem[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= bad_access;
        end
    end

    assign bus.misalign = misalign_q;

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.alu_result_to_mem[WORD_W-1:AW+2]};
`else
    assign bad_access = 1'b0;

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.alu_result_to_mem[WORD_W-1:AW+2],
                                bus.alu_result_to_mem[1:0]};
`endif

    assign mem_we = rst & bus.MEM_MemWrite & ~bad_access;
    assign mem_re = bus.MEM_MemRead & ~bad_access;

    data_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_data_mem (
        .clk     (clk),
        .rst     (rst),
        .addr_i  (word_addr),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .wdata_i (bus.write_data_to_mem),
        .rdata_o (bus.read_data_to_wb)
    );

    // NOTE: every field gets its value in one unconditional assignment, so
    // no path through this block can leave wb_d unassigned (no latch).
    always_comb begin
        wb_d.memtoreg   = bus.MEM_MemtoReg;
        wb_d.regwrite   = bus.MEM_RegWrite & ~bad_access;
        wb_d.alu_result = bus.alu_result_to_mem;
        wb_d.write_reg  = bus.write_reg_to_mem;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign bus.WB_MemtoReg      = wb_q.memtoreg;
    assign bus.WB_RegWrite      = wb_q.regwrite;
    assign bus.alu_result_to_wb = wb_q.alu_result;
    assign bus.write_reg_to_wb  = wb_q.write_reg;
    assign bus.wb_data          = wb_q.memtoreg ? bus.read_data_to_wb
                                                : wb_q.alu_result;

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
// Directed bench for mem_wb_stage (DEPTH=256). Inputs change after the
// sampling point (#1 past the rising edge); outputs are checked there too.
// Defining MEM_ALIGN_CHECK_EN also exercises the misalign path.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;
    import mem_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_wb_stage_if bus ();

    mem_wb_stage #(
        .DEPTH (256)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one instruction's MEM-stage signals, then clock it into WB.
    task automatic step(input logic rst_v, input logic rd, input logic wr,
                        input logic m2r, input logic rw,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd_reg);
        rst                   = rst_v;
        bus.MEM_MemRead       = rd;
        bus.MEM_MemWrite      = wr;
        bus.MEM_MemtoReg      = m2r;
        bus.MEM_RegWrite      = rw;
        bus.alu_result_to_mem = addr;
        bus.write_data_to_mem = wdata;
        bus.write_reg_to_mem  = rd_reg;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset edge with a store and a load presented: outputs clear, store dropped.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'hDEAD, 5'd5);
        check("rst_memtoreg",  {31'd0, bus.WB_MemtoReg}, 32'd0);
        check("rst_regwrite",  {31'd0, bus.WB_RegWrite}, 32'd0);
        check("rst_read_data", bus.read_data_to_wb,      32'd0);
        check("rst_alu",       bus.alu_result_to_wb,     32'd0);
        check("rst_write_reg", {27'd0, bus.write_reg_to_wb}, 32'd0);
        check("rst_wb_data",   bus.wb_data,              32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        check("rst_misalign",  {31'd0, bus.misalign},    32'd0);
`endif

        // Load of 0x10 after reset: the suppressed store left it at zero.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 5'd1);
        check("rst_load_0x10", bus.read_data_to_wb,  32'd0);
        check("rst_load_alu",  bus.alu_result_to_wb, 32'h10);

        // Store to 0x40: no read, so read data is forced to zero.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h12345678, 5'd0);
        check("store_rdata_zero", bus.read_data_to_wb,      32'd0);
        check("store_regwrite",   {31'd0, bus.WB_RegWrite}, 32'd0);

        // Back-to-back load of 0x40 sees the new data.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd3);
        check("load_0x40_rdata",  bus.read_data_to_wb,      32'h12345678);
        check("load_0x40_wbdata", bus.wb_data,              32'h12345678);
        check("load_memtoreg",    {31'd0, bus.WB_MemtoReg}, 32'd1);
        check("load_write_reg",   {27'd0, bus.write_reg_to_wb}, 32'd3);

        // Wrap: byte 0x400 is word 256, which aliases word 0.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h400, 32'hA5A5A5A5, 5'd0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h000, 32'h0, 5'd4);
        check("wrap_load_0x000", bus.read_data_to_wb, 32'hA5A5A5A5);

        // Simultaneous read+write returns the old word, then the new one.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h1111, 5'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 32'h2222, 5'd6);
        check("rw_same_old", bus.read_data_to_wb, 32'h1111);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 32'h0, 5'd6);
        check("rw_next_new", bus.read_data_to_wb, 32'h2222);

        // ALU passthrough to writeback.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000BEEF, 32'h0, 5'd7);
        check("pass_regwrite",  {31'd0, bus.WB_RegWrite},     32'd1);
        check("pass_write_reg", {27'd0, bus.write_reg_to_wb}, 32'd7);
        check("pass_wb_data",   bus.wb_data,                  32'h0000BEEF);
        check("pass_rdata",     bus.read_data_to_wb,          32'd0);

        // Mid-run reset clears the pipeline but keeps memory contents.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'hFFFFFFFF, 5'd9);
        check("rst2_rdata",    bus.read_data_to_wb,      32'd0);
        check("rst2_regwrite", {31'd0, bus.WB_RegWrite}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd2);
        check("rst2_mem_kept", bus.read_data_to_wb, 32'h12345678);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned store is squashed and flagged for one cycle.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h41, 32'hFFFFFFFF, 5'd8);
        check("mis_flag",     {31'd0, bus.misalign},    32'd1);
        check("mis_regwrite", {31'd0, bus.WB_RegWrite}, 32'd0);
        check("mis_rdata",    bus.read_data_to_wb,      32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd8);
        check("mis_flag_clr", {31'd0, bus.misalign},    32'd0);
        check("mis_word_kept", bus.read_data_to_wb,     32'h12345678);
        check("mis_regwrite_ok", {31'd0, bus.WB_RegWrite}, 32'd1);
`else
        // Without the check, low address bits are ignored.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h43, 32'h0, 5'd8);
        check("unaligned_load", bus.read_data_to_wb,      32'h12345678);
        check("unaligned_rw",   {31'd0, bus.WB_RegWrite}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter: DEPTH, 256, data-memory size in 32-bit words (power of two, 16..4096).
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: MEM_MemtoReg  in  1  select memory data for writeback.
REQ-005 SHALL have port: MEM_RegWrite  in  1  instruction writes register file.
REQ-006 SHALL have port: MEM_MemRead  in  1  load.
REQ-007 SHALL have port: MEM_MemWrite  in  1  store.
REQ-008 SHALL have port: alu_result_to_mem  in  32  byte address / ALU result.
REQ-009 SHALL have port: write_data_to_mem  in  32  store data.
REQ-010 SHALL have port: write_reg_to_mem  in  5  destination register.
REQ-011 SHALL have port: WB_MemtoReg  out  1  registered MEM_MemtoReg.
REQ-012 SHALL have port: WB_RegWrite  out  1  registered MEM_RegWrite (after alignment gating, REQ-026).
REQ-013 SHALL have port: read_data_to_wb  out  32  registered load data.
REQ-014 SHALL have port: alu_result_to_wb  out  32  registered ALU result.
REQ-015 SHALL have port: write_reg_to_wb  out  5  registered destination register.
REQ-016 SHALL have port: wb_data  out  32  combinational: WB_MemtoReg ? read_data_to_wb : alu_result_to_wb.

Function
REQ-017 SHALL index memory by word = alu_result_to_mem[log2(DEPTH)+1:2]; higher bits ignored (address wraps modulo DEPTH*4).
REQ-018 SHALL write write_data_to_mem to the indexed word at the rising edge when rst=1 and MEM_MemWrite=1.
REQ-019 SHALL, when rst=1 and MEM_MemRead=1, capture the indexed word into read_data_to_wb at the same edge (1-cycle load latency, data valid alongside WB controls).
REQ-020 SHALL, when MEM_MemRead=0, load 0 into read_data_to_wb.
REQ-021 SHALL, when MEM_MemRead=1 and MEM_MemWrite=1 in the same cycle, perform the write and return pre-write (old) contents.
REQ-022 SHALL make a store visible to a load to the same word issued in the next cycle (back-to-back store->load returns new data).
REQ-023 SHALL register all other MEM_* controls and alu_result/write_reg unchanged into their WB counterparts every non-reset edge; no stall or enable.

Reset
REQ-024 SHALL, on a rising edge with rst=0, clear WB_MemtoReg, WB_RegWrite, read_data_to_wb, alu_result_to_wb and write_reg_to_wb to 0 and suppress any memory write presented that cycle.
REQ-025 SHALL NOT clear memory contents on reset; memory initialises to all-zero at simulation start only.

Configuration
REQ-026 SHALL, with MEM_ALIGN_CHECK_EN defined, add output misalign (1 bit, reset 0), set for one cycle after any access (MemRead|MemWrite) with addr[1:0]!=0; such an access performs no write, returns read_data_to_wb=0, and forces WB_RegWrite=0.
REQ-027 SHALL, without MEM_ALIGN_CHECK_EN, omit misalign and ignore addr[1:0].

Structure
REQ-028 SHALL place WORD_W=32, REG_W=5 and DEPTH default in shared package mem_pkg.
REQ-029 SHALL implement storage as sub-module data_mem (single-port synchronous RAM, write-first disabled, read-old-data).

Verification
REQ-030 Reset: rst=0 one edge with MemWrite=1, addr 0x10, data 0xDEAD -> all outputs 0; later load of 0x10 returns 0.
REQ-031 Store/load: store 0x12345678 to 0x40, next cycle load 0x40, MemtoReg=1 -> read_data_to_wb=0x12345678, wb_data=0x12345678 one cycle after load.
REQ-032 Wrap: DEPTH=256, store 0xA5A5A5A5 to 0x400, load 0x000 -> 0xA5A5A5A5.
REQ-033 Simultaneous: word 0x20 holds 0x1111, read+write 0x2222 same cycle -> read_data_to_wb=0x1111; next load -> 0x2222.
REQ-034 Passthrough: MemtoReg=0, RegWrite=1, alu 0x0000BEEF, reg 7 -> WB_RegWrite=1, write_reg_to_wb=7, wb_data=0x0000BEEF.
REQ-035 Alignment (MEM_ALIGN_CHECK_EN): store to 0x41 -> misalign=1 one cycle, word 0x40 unchanged, WB_RegWrite=0.
